// File: rtl/showcase1_pkg.sv
// Shared definitions for the showcase1 stream ALU: compare-flag layout and code lookup.
package showcase1_pkg;

  localparam int CMP_A_LT = 0;
  localparam int CMP_A_GT = 1;
  localparam int CMP_B_LE = 2;
  localparam int CMP_B_GE = 3;
  localparam int CMP_B_NE = 4;
  localparam int CMP_B_EQ = 5;
  localparam int CMP_W    = 6;

  typedef logic [CMP_W-1:0] cmp_flags_t;

  // Only a in 1..3 has a dedicated code; the caller folds a>=4 into the default.
  function automatic logic [7:0] code_lut(input logic [1:0] a_lo);
    logic [7:0] c;
    case (a_lo)
      2'd1:    c = 8'h00;
      2'd2:    c = 8'h01;
      2'd3:    c = 8'h03;
      default: c = 8'h04;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/showcase1_delay_line.sv
// Free-running shift register of DEPTH stages, synchronously cleared.
module showcase1_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/showcase1.sv
// Valid/ready stream ALU with compare flags, code lookup, sticky flag, index delay and capture RAM.
module showcase1
  import showcase1_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIT_WIDTH   = 16,
  parameter int CMP_CONST   = 4,
  parameter int DELAY_DEPTH = 2,
  parameter int RAM_DEPTH   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_a,
  input  logic [DATA_WIDTH-1:0]        in_b,
  input  logic                         in_e,
  input  logic                         f_clr,
  input  logic [$clog2(RAM_DEPTH)-1:0] idx_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_sum,
  output logic [CMP_W-1:0]             out_cmp,
  output logic [FIT_WIDTH-1:0]         out_fitted,
  output logic [7:0]                   out_code,
  output logic                         f,
  output logic [$clog2(RAM_DEPTH)-1:0] idx_out,
  output logic [7:0]                   rd_data,
  output logic [CNT_WIDTH-1:0]         txn_cnt
);

  localparam int IDX_W = $clog2(RAM_DEPTH);
  localparam logic [DATA_WIDTH-1:0]        C_U = DATA_WIDTH'(CMP_CONST);
  localparam logic signed [DATA_WIDTH-1:0] C_S = DATA_WIDTH'(CMP_CONST);

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  cmp_flags_t            cmp_q, cmp_d;
  logic [FIT_WIDTH-1:0]  fit_q;
  logic [7:0]            code_q, code_d;
  logic                  f_q, f_d;
  logic [IDX_W-1:0]      wp_q, wp_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [7:0]            rd_q;
  logic [7:0]            mem_q [RAM_DEPTH];
  logic                  acc;

  assign in_ready = !vld_q || out_ready;
  assign acc      = in_valid && in_ready;

  always_comb begin
    sum_d            = in_a + in_b;
    cmp_d            = '0;
    cmp_d[CMP_B_EQ]  = $signed(in_b) == C_S;
    cmp_d[CMP_B_NE]  = $signed(in_b) != C_S;
    cmp_d[CMP_B_GE]  = $signed(in_b) >= C_S;
    cmp_d[CMP_B_LE]  = $signed(in_b) <= C_S;
    cmp_d[CMP_A_GT]  = in_a > C_U;
    cmp_d[CMP_A_LT]  = in_a < C_U;
    code_d           = (in_a[DATA_WIDTH-1:2] == '0) ? code_lut(in_a[1:0]) : 8'h04;
    vld_d            = acc ? 1'b1 : (out_ready ? 1'b0 : vld_q);
    // Set wins over clear when both land in the same cycle.
    f_d              = (f_q && !f_clr) || (acc && in_e);
    wp_d             = wp_q;
    cnt_d            = cnt_q;
    if (acc) begin
      wp_d = (wp_q == IDX_W'(RAM_DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      sum_q  <= '0;
      cmp_q  <= '0;
      fit_q  <= '0;
      code_q <= '0;
      f_q    <= 1'b0;
      wp_q   <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      vld_q <= vld_d;
      f_q   <= f_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      if (acc) begin
        sum_q  <= sum_d;
        cmp_q  <= cmp_d;
        fit_q  <= in_a[FIT_WIDTH-1:0];
        code_q <= code_d;
      end
      // Non-pow2 depth leaves unmapped index codes; those read as zero.
      rd_q <= ({1'b0, idx_out} < (IDX_W+1)'(RAM_DEPTH)) ? mem_q[idx_out] : 8'h00;
    end
  end

  // Capture RAM has no reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (acc && !rst) mem_q[wp_q] <= in_a[7:0];
  end

  showcase1_delay_line #(.WIDTH(IDX_W), .DEPTH(DELAY_DEPTH)) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i (idx_in),
    .q_o (idx_out)
  );

  assign out_valid  = vld_q;
  assign out_sum    = sum_q;
  assign out_cmp    = cmp_q;
  assign out_fitted = fit_q;
  assign out_code   = code_q;
  assign f          = f_q;
  assign rd_data    = rd_q;
  assign txn_cnt    = cnt_q;

endmodule
